// File: rtl/aib_cfg_avmm_pkg.sv
// Shared types and address-field constants for the AIB cfg_avmm responder.
// Holds the responder FSM state enum and a helper that decides whether a word index is backed by a CSR.
package aib_cfg_avmm_pkg;

    localparam int CHAN_MSB = 16;
    localparam int CHAN_LSB = 11;
    localparam int WORD_MSB = 10;
    localparam int WORD_LSB = 2;
    localparam int WORD_W   = WORD_MSB - WORD_LSB + 1;
    localparam int IDX_W    = 5;

    localparam int CSR_ID     = 0;
    localparam int CSR_STATUS = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_RDPIPE = 2'd2,
        ST_RDRESP = 2'd3
    } state_e;

    // Only word indices below NUM_REGS with the upper word bits clear reach a CSR.
    function automatic logic word_mapped(input logic [WORD_W-1:0] word, input int num_regs);
        return (word[WORD_W-1:IDX_W] == '0) && (int'(word[IDX_W-1:0]) < num_regs);
    endfunction

endpackage

// File: rtl/aib_cfg_csr_reg.sv
// One 32-bit read/write CSR with per-byte write enables.
// Asynchronous active-low reset loads RST_VAL.
module aib_cfg_csr_reg
    import aib_cfg_avmm_pkg::*;
#(
    parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] q
);

    logic [31:0] data_q;
    logic [31:0] data_d;

    always_comb begin
        data_d = data_q;
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    data_d[b*8 +: 8] = wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/aib_cfg_avmm_responder.sv
// Avalon-MM configuration responder for one AIB channel: decodes channel-addressed requests into a CSR bank.
// Build option CFG_AVMM_RDATA_PIPE_EN adds a second read-data register stage (rdatavld one cycle later).
module aib_cfg_avmm_responder
    import aib_cfg_avmm_pkg::*;
#(
    parameter int          NUM_REGS = 16,
    parameter logic [31:0] ID_VALUE = 32'h0AB1_0001,
    parameter logic [31:0] RST_VAL  = 32'h0000_0000
) (
    input  logic                     i_cfg_avmm_clk,
    input  logic                     i_cfg_avmm_rst_n,
    input  logic [5:0]               i_channel_id,
    input  logic [16:0]              i_cfg_avmm_addr,
    input  logic [3:0]               i_cfg_avmm_byte_en,
    input  logic                     i_cfg_avmm_read,
    input  logic                     i_cfg_avmm_write,
    input  logic [31:0]              i_cfg_avmm_wdata,
    input  logic [31:0]              i_csr_status,
    output logic [31:0]              o_cfg_avmm_rdata,
    output logic                     o_cfg_avmm_rdatavld,
    output logic                     o_cfg_avmm_waitreq,
    output logic [NUM_REGS*32-1:0]   o_csr_q
);

    // Handshake: a selected request is stalled (waitreq=1) for its first cycle in IDLE and
    // accepted on the following cycle, where waitreq=0. Request inputs are only sampled in IDLE;
    // rdata is meaningful only while rdatavld is high, which lasts exactly one cycle.

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               wr_q, wr_d;
    logic [31:0]        rdata_q, rdata_d;
`ifdef CFG_AVMM_RDATA_PIPE_EN
    logic [31:0]        pipe_q, pipe_d;
`endif

    logic                   sel;
    logic                   csr_we;
    logic [31:0]            rd_val;
    logic [NUM_REGS*32-1:0] csr_flat;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^i_cfg_avmm_addr[WORD_LSB-1:0];

    assign sel = (i_cfg_avmm_read | i_cfg_avmm_write) &&
                 (i_cfg_avmm_addr[CHAN_MSB:CHAN_LSB] == i_channel_id);

    assign csr_we = (state_q == ST_ACCEPT) && wr_q;

    // CSR0 is a constant ID and CSR1 is a live view of the status input.
    assign csr_flat[CSR_ID*32 +: 32]     = ID_VALUE;
    assign csr_flat[CSR_STATUS*32 +: 32] = i_csr_status;

    for (genvar n = 2; n < NUM_REGS; n++) begin : g_csr
        aib_cfg_csr_reg #(
            .RST_VAL (RST_VAL)
        ) u_csr (
            .clk   (i_cfg_avmm_clk),
            .rst_n (i_cfg_avmm_rst_n),
            .we    (csr_we && (word_q == WORD_W'(n))),
            .be    (be_q),
            .wdata (wdata_q),
            .q     (csr_flat[n*32 +: 32])
        );
    end

    always_comb begin
        rd_val = '0;
        if (word_mapped(word_q, NUM_REGS)) begin
            for (int n = 0; n < NUM_REGS; n++) begin
                if (word_q[IDX_W-1:0] == IDX_W'(n)) begin
                    rd_val = csr_flat[n*32 +: 32];
                end
            end
        end
    end

    always_comb begin
        state_d             = state_q;
        word_d              = word_q;
        be_d                = be_q;
        wdata_d             = wdata_q;
        wr_d                = wr_q;
        rdata_d             = rdata_q;
`ifdef CFG_AVMM_RDATA_PIPE_EN
        pipe_d              = pipe_q;
`endif
        o_cfg_avmm_waitreq  = 1'b0;
        o_cfg_avmm_rdatavld = 1'b0;

        case (state_q)
            ST_IDLE: begin
                o_cfg_avmm_waitreq = sel;
                if (sel) begin
                    state_d = ST_ACCEPT;
                    word_d  = i_cfg_avmm_addr[WORD_MSB:WORD_LSB];
                    be_d    = i_cfg_avmm_byte_en;
                    wdata_d = i_cfg_avmm_wdata;
                    // Read and write together resolve to a write.
                    wr_d    = i_cfg_avmm_write;
                end
            end
            ST_ACCEPT: begin
                if (wr_q) begin
                    state_d = ST_IDLE;
                end else begin
`ifdef CFG_AVMM_RDATA_PIPE_EN
                    pipe_d  = rd_val;
                    state_d = ST_RDPIPE;
`else
                    rdata_d = rd_val;
                    state_d = ST_RDRESP;
`endif
                end
            end
            ST_RDPIPE: begin
`ifdef CFG_AVMM_RDATA_PIPE_EN
                rdata_d = pipe_q;
                state_d = ST_RDRESP;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_RDRESP: begin
                o_cfg_avmm_rdatavld = 1'b1;
                state_d             = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_cfg_avmm_clk or negedge i_cfg_avmm_rst_n) begin
        if (!i_cfg_avmm_rst_n) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
`ifdef CFG_AVMM_RDATA_PIPE_EN
            pipe_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
`ifdef CFG_AVMM_RDATA_PIPE_EN
            pipe_q  <= pipe_d;
`endif
        end
    end

    assign o_cfg_avmm_rdata = rdata_q;
    assign o_csr_q          = csr_flat;

endmodule

// File: tb/tb_aib_cfg_avmm_responder.sv
// Self-checking bench for aib_cfg_avmm_responder: directed vector table, reset-in-flight sequence,
// and randomized traffic against a register-array reference model.
module tb_aib_cfg_avmm_responder;

    localparam int          NUM_REGS = 16;
    localparam logic [31:0] ID_VALUE = 32'h0AB1_0001;
    localparam logic [5:0]  MY_CH    = 6'd5;
`ifdef CFG_AVMM_RDATA_PIPE_EN
    localparam int          RD_LAT   = 3;
`else
    localparam int          RD_LAT   = 2;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [16:0]            addr = '0;
    logic [3:0]             byte_en = '0;
    logic                   read = 1'b0;
    logic                   write = 1'b0;
    logic [31:0]            wdata = '0;
    logic [31:0]            status_v = 32'hA5A5_0F0F;
    logic [31:0]            rdata;
    logic                   rdatavld;
    logic                   waitreq;
    logic [NUM_REGS*32-1:0] csr_q;

    always #5 clk = ~clk;

    aib_cfg_avmm_responder #(
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE),
        .RST_VAL  (32'h0000_0000)
    ) dut (
        .i_cfg_avmm_clk      (clk),
        .i_cfg_avmm_rst_n    (rst_n),
        .i_channel_id        (MY_CH),
        .i_cfg_avmm_addr     (addr),
        .i_cfg_avmm_byte_en  (byte_en),
        .i_cfg_avmm_read     (read),
        .i_cfg_avmm_write    (write),
        .i_cfg_avmm_wdata    (wdata),
        .i_csr_status        (status_v),
        .o_cfg_avmm_rdata    (rdata),
        .o_cfg_avmm_rdatavld (rdatavld),
        .o_cfg_avmm_waitreq  (waitreq),
        .o_csr_q             (csr_q)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [NUM_REGS];
    logic [31:0] exp_q [$];

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [5:0]  ch;
        logic [8:0]  word;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        exp_vld;
        logic [31:0] exp_rdata;
        logic [31:0] exp_csr2;
    } vec_t;

    vec_t vecs [20];

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic checkint(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [8:0] word);
        int idx;
        idx = int'(word[4:0]);
        if (word[8:5] != 4'd0 || idx >= NUM_REGS) return 32'h0;
        if (idx == 0) return ID_VALUE;
        if (idx == 1) return status_v;
        return model[idx];
    endfunction

    task automatic model_write(input logic [8:0] word, input logic [3:0] be, input logic [31:0] d);
        int idx;
        idx = int'(word[4:0]);
        if (word[8:5] == 4'd0 && idx >= 2 && idx < NUM_REGS) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
            end
        end
    endtask

    task automatic check_csr(input string name);
        logic [NUM_REGS*32-1:0] exp_flat;
        for (int n = 0; n < NUM_REGS; n++) begin
            exp_flat[n*32 +: 32] = (n == 0) ? ID_VALUE : (n == 1) ? status_v : model[n];
        end
        n_checks++;
        if (csr_q !== exp_flat) begin
            n_fail++;
            $display("FAIL %s csr_q: got %h expected %h", name, csr_q, exp_flat);
        end
    endtask

    // Starts just after a rising edge with the DUT idle; holds the request through the accept cycle.
    task automatic do_req(input logic rd, input logic wr, input logic [5:0] ch, input logic [8:0] word,
                          input logic [3:0] be, input logic [31:0] d, input string name,
                          output logic got_vld, output logic [31:0] got_rdata);
        logic sel_e;
        logic exp_vld;
        int   vld_cycle;
        int   n_vld;
        sel_e   = (rd | wr) && (ch == MY_CH);
        exp_vld = sel_e && rd && !wr;
        if (exp_vld) exp_q.push_back(model_read(word));
        addr      = {ch, word, 2'($urandom_range(0, 3))};
        byte_en   = be;
        wdata     = d;
        read      = rd;
        write     = wr;
        vld_cycle = -1;
        n_vld     = 0;
        got_vld   = 1'b0;
        got_rdata = '0;
        for (int c = 0; c < RD_LAT + 3; c++) begin
            @(negedge clk);
            if (c == 0) check1({name, " waitreq stall"}, waitreq, sel_e);
            if (c == 1) check1({name, " waitreq accept"}, waitreq, 1'b0);
            if (rdatavld) begin
                n_vld++;
                got_vld   = 1'b1;
                got_rdata = rdata;
                if (vld_cycle < 0) vld_cycle = c;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s unexpected rdatavld: got 1 expected 0", name);
                end else begin
                    check32({name, " rdata"}, rdata, exp_q.pop_front());
                end
            end
            @(posedge clk);
            #1;
            if (c == 1) begin
                read  = 1'b0;
                write = 1'b0;
            end
        end
        checkint({name, " rdatavld cycle"}, vld_cycle, exp_vld ? RD_LAT : -1);
        checkint({name, " rdatavld count"}, n_vld, exp_vld ? 1 : 0);
        if (sel_e && wr) model_write(word, be, d);
        check_csr(name);
    endtask

    initial begin
        logic        gv;
        logic [31:0] gd;
        int          nv;
        logic        r_rd, r_wr;
        logic [5:0]  r_ch;
        logic [8:0]  r_word;
        int          k;

        for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;

        //               rd    wr    ch    word     be     wdata          vld   rdata          csr2
        vecs[0]  = '{1'b0, 1'b1, 6'd5, 9'h002, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b1, 1'b0, 6'd5, 9'h002, 4'hF, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 1'b1, 6'd5, 9'h003, 4'h5, 32'h1122_3344, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 1'b0, 6'd5, 9'h003, 4'hF, 32'h0000_0000, 1'b1, 32'h0022_0044, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 1'b1, 6'd6, 9'h002, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 1'b0, 6'd6, 9'h002, 4'hF, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b1, 1'b0, 6'd5, 9'h002, 4'hF, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[7]  = '{1'b1, 1'b0, 6'd5, 9'h000, 4'hF, 32'h0000_0000, 1'b1, 32'h0AB1_0001, 32'hDEAD_BEEF};
        vecs[8]  = '{1'b1, 1'b0, 6'd5, 9'h001, 4'hF, 32'h0000_0000, 1'b1, 32'hA5A5_0F0F, 32'hDEAD_BEEF};
        vecs[9]  = '{1'b0, 1'b1, 6'd5, 9'h000, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[10] = '{1'b0, 1'b1, 6'd5, 9'h001, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[11] = '{1'b1, 1'b0, 6'd5, 9'h000, 4'hF, 32'h0000_0000, 1'b1, 32'h0AB1_0001, 32'hDEAD_BEEF};
        vecs[12] = '{1'b1, 1'b0, 6'd5, 9'h001, 4'hF, 32'h0000_0000, 1'b1, 32'hA5A5_0F0F, 32'hDEAD_BEEF};
        vecs[13] = '{1'b1, 1'b0, 6'd5, 9'h1FF, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[14] = '{1'b0, 1'b1, 6'd5, 9'h1FF, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[15] = '{1'b1, 1'b1, 6'd5, 9'h002, 4'hF, 32'h0000_0055, 1'b0, 32'h0000_0000, 32'h0000_0055};
        vecs[16] = '{1'b1, 1'b0, 6'd5, 9'h002, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0055, 32'h0000_0055};
        vecs[17] = '{1'b0, 1'b1, 6'd5, 9'h004, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h0000_0055};
        vecs[18] = '{1'b1, 1'b0, 6'd5, 9'h004, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0055};
        vecs[19] = '{1'b1, 1'b0, 6'd5, 9'h010, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0055};

        // Clock/reset: check reset state while held, release away from the rising edge.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("reset waitreq", waitreq, 1'b0);
        check1("reset rdatavld", rdatavld, 1'b0);
        check32("reset rdata", rdata, 32'h0);
        check_csr("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table.
        for (int i = 0; i < 20; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            do_req(vecs[i].rd, vecs[i].wr, vecs[i].ch, vecs[i].word, vecs[i].be, vecs[i].wdata, nm, gv, gd);
            check1({nm, " table vld"}, gv, vecs[i].exp_vld);
            if (vecs[i].exp_vld) check32({nm, " table rdata"}, gd, vecs[i].exp_rdata);
            check32({nm, " csr2"}, csr_q[95:64], vecs[i].exp_csr2);
        end

        // Reset asserted while the read response is on the bus.
        do_req(1'b0, 1'b1, MY_CH, 9'h002, 4'hF, 32'h1234_5678, "prerst wr", gv, gd);
        addr = {MY_CH, 9'h002, 2'b00};
        read = 1'b1;
        for (int c = 0; c < RD_LAT; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) read = 1'b0;
        end
        @(negedge clk);
        check1("rst rdatavld before", rdatavld, 1'b1);
        check32("rst rdata before", rdata, 32'h1234_5678);
        rst_n = 1'b0;
        #1;
        check1("rst rdatavld dropped", rdatavld, 1'b0);
        check32("rst csr2 cleared", csr_q[95:64], 32'h0);
        check32("rst rdata cleared", rdata, 32'h0);
        for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        repeat (6) begin
            @(negedge clk);
            if (rdatavld) nv++;
        end
        checkint("rst no late rdatavld", nv, 0);
        @(posedge clk);
        #1;
        do_req(1'b1, 1'b0, MY_CH, 9'h002, 4'hF, 32'h0, "postrst rd", gv, gd);
        do_req(1'b0, 1'b1, MY_CH, 9'h002, 4'h3, 32'hCAFE_F00D, "postrst wr", gv, gd);
        do_req(1'b1, 1'b0, MY_CH, 9'h002, 4'hF, 32'h0, "postrst rd2", gv, gd);
        check32("postrst rd2 value", gd, 32'h0000_F00D);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 150; i++) begin
            k      = $urandom_range(0, 9);
            r_ch   = (k == 0) ? 6'($urandom_range(0, 63)) : MY_CH;
            k      = $urandom_range(0, 19);
            r_word = (k == 19) ? 9'($urandom_range(0, 511)) : 9'(k);
            k      = $urandom_range(0, 3);
            r_rd   = (k != 1);
            r_wr   = (k == 1) || (k == 2);
            status_v = $urandom;
            do_req(r_rd, r_wr, r_ch, r_word, 4'($urandom_range(0, 15)), $urandom,
                   $sformatf("rnd%0d", i), gv, gd);
        end

        checkint("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aib_cfg_avmm_responder.md
Name: aib_cfg_avmm_responder

Overview:
Avalon-MM configuration responder for one AIB adapter channel. It terminates the cfg_avmm bus driven by the fabric or testbench initiator and decodes channel-addressed requests into a small CSR bank. It returns read data with a fixed, handshaked latency. It sits in the i_cfg_avmm_clk domain behind the channel's avmm fabric, which ORs responses from all channels.

Parameters:
NUM_REGS, 16, number of 32-bit CSRs (2..32); index = addr[6:2]
ID_VALUE, 32'h0AB1_0001, read-only contents of CSR 0
RST_VAL, 32'h0000_0000, reset value of RW CSRs 2..NUM_REGS-1

Ports:
i_cfg_avmm_clk  in  1  config clock
i_cfg_avmm_rst_n  in  1  asynchronous active-low reset
i_channel_id  in  6  static channel number for this instance
i_cfg_avmm_addr  in  17  byte address; [16:11] channel select, [10:2] word, [1:0] ignored
i_cfg_avmm_byte_en  in  4  write byte lanes
i_cfg_avmm_read  in  1  read request
i_cfg_avmm_write  in  1  write request
i_cfg_avmm_wdata  in  32  write data
i_csr_status  in  32  live status, returned by CSR 1
o_cfg_avmm_rdata  out  32  read data, valid only with rdatavld
o_cfg_avmm_rdatavld  out  1  one-cycle read data strobe
o_cfg_avmm_waitreq  out  1  stall; request accepted on the cycle it is low
o_csr_q  out  NUM_REGS*32  flattened CSR contents; CSR n at [n*32+:32]

Behaviour:
- Reset (async assert, sync release): state IDLE, waitreq=0, rdatavld=0, rdata=0, RW CSRs=RST_VAL.
- sel = (read|write) & (addr[16:11]==i_channel_id). Unselected requests are ignored: waitreq=0, no rdatavld, no CSR change.
- FSM states IDLE, ACCEPT, RDRESP.
- IDLE: waitreq = sel (combinational). If sel, go to ACCEPT and latch addr, byte_en, wdata and the op.
- ACCEPT: waitreq=0. Write: each CSR byte with byte_en[b]=1 is updated on this edge; the FSM returns to IDLE. Read: rdata is captured and the FSM goes to RDRESP.
- RDRESP: rdatavld=1 for exactly one cycle with the held rdata. The FSM then returns to IDLE, and rdata holds its value afterwards.
- Cycle timing: a request at cycle 0 is stalled at 0, accepted at 1, and rdatavld occurs at 2. The read turnaround is therefore 3 cycles. A back-to-back request is seen in IDLE at cycle 3.
- Read map: CSR0 returns ID_VALUE. CSR1 returns i_csr_status, sampled in ACCEPT. CSRs 2..NUM_REGS-1 return their stored value.
- Unmapped word (addr[10:7]!=0 or index>=NUM_REGS): a read returns 32'h0 with the normal handshake; a write is accepted and discarded.
- Writes to CSR0 and CSR1 are accepted and have no effect.
- byte_en=4'b0000 write: accepted, with no change.
- read and write asserted together while selected: treated as a write; no rdatavld is produced.
- Requests that change during ACCEPT or RDRESP are ignored. Only the values latched in IDLE are used.
- Reset mid-transaction: the pending response is dropped and no rdatavld is produced after release.
- o_csr_q is a direct view of the register outputs, with no added latency.

Optional Feature:
CFG_AVMM_RDATA_PIPE_EN
- Defined: adds an RDPIPE state between ACCEPT and RDRESP. rdata is registered twice and rdatavld occurs at cycle 3. The write path is unchanged.
- Undefined: timing exactly as above.

Decomposition:
- Package aib_cfg_avmm_pkg holds:
  - state enum
  - address field constants (CHAN_MSB=16, CHAN_LSB=11, WORD_MSB=10, WORD_LSB=2)
  - CSR index constants CSR_ID=0, CSR_STATUS=1
- Sub-module aib_cfg_csr_reg: one 32-bit register with byte-enable write and RST_VAL reset, instantiated NUM_REGS-2 times.

Test Plan:
1. i_channel_id=6'd5. Write addr={6'd5,11'h008}, wdata=32'hDEADBEEF, be=4'hF, then read the same address. Expected: waitreq high 1 cycle, rdatavld at cycle 2, rdata=32'hDEADBEEF, o_csr_q[95:64]=32'hDEADBEEF.
2. Byte lanes: write 32'h11223344 with be=4'b0101 over RST_VAL 0. Expected: readback 32'h00220044.
3. Channel mismatch: addr[16:11]=6'd6 with write 32'hFFFFFFFF. Expected: waitreq stays 0, no CSR change, and a read of channel 6 produces no rdatavld.
4. Reads of CSR0 and CSR1 with i_csr_status=32'hA5A5_0F0F. Expected: 32'h0AB1_0001 and 32'hA5A5_0F0F; writes to both leave the values unchanged. Unmapped read of word 9'h1FF returns 0.
5. read=write=1 to CSR2 with wdata 32'h55. Expected: CSR2=32'h55, no rdatavld.
6. Assert reset during RDRESP. Expected: rdatavld=0 immediately, CSR2 returns to 0, and the next read is handled normally. Repeat with CFG_AVMM_RDATA_PIPE_EN defined: rdatavld at cycle 3.
